// File: rtl/mips_mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller (master) and the datapath (slave).
// MC_CTRL_PERF_EN adds the cycle_cnt/instr_cnt performance counters.
interface mips_mc_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [2:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       sign_imm;
    logic       reg_write;
    logic [2:0] reg_dst;
    logic [2:0] reg_data_src;
    logic       illegal;
    logic       err_timeout;
    logic [3:0] state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
        output alu_src_a, alu_src_b, alu_control, sign_imm,
        output reg_write, reg_dst, reg_data_src, illegal, err_timeout, state
`ifdef MC_CTRL_PERF_EN
        , output cycle_cnt, instr_cnt
`endif
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
        input  alu_src_a, alu_src_b, alu_control, sign_imm,
        input  reg_write, reg_dst, reg_data_src, illegal, err_timeout, state
`ifdef MC_CTRL_PERF_EN
        , input cycle_cnt, instr_cnt
`endif
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with memory stall.
// Define MC_CTRL_PERF_EN to add the cycle and instruction counters.
module mips_mc_ctrl #(
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           reset,
    mips_mc_ctrl_if.master bus
);
    localparam int unsigned WAIT_W = $clog2(FETCH_TIMEOUT + 1);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_WB_R     = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_WB_I     = 4'd5;
    localparam logic [3:0] S_MEM_ADDR = 4'd6;
    localparam logic [3:0] S_MEM_RD   = 4'd7;
    localparam logic [3:0] S_MEM_WB   = 4'd8;
    localparam logic [3:0] S_MEM_WR   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_JAL      = 4'd12;
    localparam logic [3:0] S_JR       = 4'd13;

    logic [3:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              err_q, err_d;
    logic              waiting;
`ifdef MC_CTRL_PERF_EN
    logic [31:0]       cycle_cnt_q, cycle_cnt_d;
    logic [31:0]       instr_cnt_q, instr_cnt_d;
`endif

    // Next state, sticky flags and memory wait counter
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        err_d     = err_q;
        wait_d    = wait_q;
        waiting   = 1'b0;
        case (state_q)
            S_FETCH: begin
                waiting = !bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opcode)
                    6'h00: begin
                        case (bus.funct)
                            6'h21, 6'h23: state_d = S_EXEC_R;
                            6'h08:        state_d = S_JR;
                            default: begin
                                illegal_d = 1'b1;
                                state_d   = S_FETCH;
                            end
                        endcase
                    end
                    6'h0d, 6'h0f: state_d = S_EXEC_I;
                    6'h23, 6'h2b: state_d = S_MEM_ADDR;
                    6'h04:        state_d = S_BRANCH;
                    6'h02:        state_d = S_JUMP;
                    6'h03:        state_d = S_JAL;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = (bus.opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                waiting = !bus.mem_ready;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WR: begin
                waiting = !bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (waiting && (wait_q != WAIT_W'(FETCH_TIMEOUT))) begin
            wait_d = wait_q + WAIT_W'(1);
        end
        if (wait_d == WAIT_W'(FETCH_TIMEOUT)) err_d = 1'b1;
    end

`ifdef MC_CTRL_PERF_EN
    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        instr_cnt_d = instr_cnt_q;
        if ((state_q != S_FETCH) && (state_d == S_FETCH)) instr_cnt_d = instr_cnt_q + 32'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            err_q     <= 1'b0;
`ifdef MC_CTRL_PERF_EN
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
`ifdef MC_CTRL_PERF_EN
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
`endif
        end
    end

    // Moore datapath controls; fetch handshake qualifies ir_we/pc_we, reset blanks everything
    always_comb begin
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.ir_we        = 1'b0;
        bus.pc_we        = 1'b0;
        bus.pc_src       = 3'd0;
        bus.alu_src_a    = 1'b0;
        bus.alu_src_b    = 2'd0;
        bus.alu_control  = 3'd0;
        bus.sign_imm     = 1'b0;
        bus.reg_write    = 1'b0;
        bus.reg_dst      = 3'd0;
        bus.reg_data_src = 3'd0;
        case (state_q)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'd1;
                bus.ir_we     = bus.mem_ready;
                bus.pc_we     = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'd3;
                bus.sign_imm  = 1'b1;
            end
            S_EXEC_R: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = (bus.funct == 6'h23) ? 3'd1 : 3'd0;
            end
            S_WB_R: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 3'd1;
            end
            S_EXEC_I: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'd2;
                bus.alu_control = (bus.opcode == 6'h0f) ? 3'd3 : 3'd2;
            end
            S_WB_I: bus.reg_write = 1'b1;
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.sign_imm  = 1'b1;
            end
            S_MEM_RD: begin
                bus.mem_req      = 1'b1;
                bus.mem_addr_sel = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write    = 1'b1;
                bus.reg_data_src = 3'd1;
            end
            S_MEM_WR: begin
                bus.mem_req      = 1'b1;
                bus.mem_we       = 1'b1;
                bus.mem_addr_sel = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = 3'd1;
                bus.pc_we       = bus.zero;
                bus.pc_src      = 3'd1;
            end
            S_JUMP: begin
                bus.pc_we  = 1'b1;
                bus.pc_src = 3'd2;
            end
            S_JAL: begin
                bus.pc_we        = 1'b1;
                bus.pc_src       = 3'd2;
                bus.reg_write    = 1'b1;
                bus.reg_dst      = 3'd2;
                bus.reg_data_src = 3'd2;
            end
            S_JR: begin
                bus.pc_we  = 1'b1;
                bus.pc_src = 3'd3;
            end
            default: ;
        endcase
        if (reset) begin
            bus.mem_req      = 1'b0;
            bus.mem_we       = 1'b0;
            bus.mem_addr_sel = 1'b0;
            bus.ir_we        = 1'b0;
            bus.pc_we        = 1'b0;
            bus.pc_src       = 3'd0;
            bus.alu_src_a    = 1'b0;
            bus.alu_src_b    = 2'd0;
            bus.alu_control  = 3'd0;
            bus.sign_imm     = 1'b0;
            bus.reg_write    = 1'b0;
            bus.reg_dst      = 3'd0;
            bus.reg_data_src = 3'd0;
        end
    end

    assign bus.state       = state_q;
    assign bus.illegal     = illegal_q;
    assign bus.err_timeout = err_q;
`ifdef MC_CTRL_PERF_EN
    assign bus.cycle_cnt   = cycle_cnt_q;
    assign bus.instr_cnt   = instr_cnt_q;
`endif
endmodule
